// File: rtl/exec_decode_unit_if.sv
// rtl/exec_decode_unit_if.sv - issue/result bundle for the decode/execute stage
interface exec_decode_unit_if;
  // issue side
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  // result side
  logic        out_valid;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        alu_src;
  logic        branch;
  logic        jump;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] target;
  logic [31:0] link;

  // Issuer: presents the decoded operands, consumes the registered results
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, imm,
    input  out_valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src,
    input  branch, jump, alu_op, alu_ctrl, alu_result, zero, branch_taken,
    input  target, link
  );

  // Stage: consumes operands, drives the registered results
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, imm,
    output out_valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src,
    output branch, jump, alu_op, alu_ctrl, alu_result, zero, branch_taken,
    output target, link
  );
endinterface

// File: rtl/exec_decode_unit.sv
// rtl/exec_decode_unit.sv - registered RV32I control decode, ALU and branch/jump target stage
module exec_decode_unit (
  input  logic               clk_i,
  input  logic               rst_ni,
  exec_decode_unit_if.slave  edu_if
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  assign opcode            = edu_if.instr[6:0];
  assign funct3            = edu_if.instr[14:12];
  assign funct7_b5         = edu_if.instr[30];
  // register/destination specifiers are resolved upstream
  assign unused_instr_bits = ^{edu_if.instr[31], edu_if.instr[29:15], edu_if.instr[11:7]};

  // next-state values
  logic        reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d;
  logic        alu_src_d, branch_d, jump_d;
  logic [1:0]  alu_op_d;
  logic [3:0]  alu_ctrl_d;
  logic [31:0] alu_result_d;
  logic        zero_d;
  logic        branch_taken_d;
  logic [31:0] target_d;
  logic [31:0] link_d;

  // registered outputs
  logic        out_valid_q;
  logic        reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic        alu_src_q, branch_q, jump_q;
  logic [1:0]  alu_op_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] alu_result_q;
  logic        zero_q;
  logic        branch_taken_q;
  logic [31:0] target_q;
  logic [31:0] link_q;

  // ALU operands and branch helpers
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        br_cond;
  logic [31:0] jalr_sum;

  // Main control: opcode to strobes and ALU-op class
  always_comb begin
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alu_op_d     = 2'b00;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = 2'b11;
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_BR: begin
        branch_d = 1'b1;
        alu_op_d = 2'b01;
      end
      OP_JAL: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
      end
      OP_JALR: begin
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
        alu_src_d   = 1'b1;
      end
      default: begin
        reg_write_d = 1'b0;
      end
    endcase
  end

  // ALU control: class plus funct3/funct7 to operation; only R-type 000 may subtract
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (alu_op_d)
      2'b00: alu_ctrl_d = ALU_ADD;
      2'b01: alu_ctrl_d = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl_d = (alu_op_d == 2'b10 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_d = ALU_SLL;
          3'b010:  alu_ctrl_d = ALU_SLT;
          3'b011:  alu_ctrl_d = ALU_SLTU;
          3'b100:  alu_ctrl_d = ALU_XOR;
          3'b101:  alu_ctrl_d = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_d = ALU_OR;
          default: alu_ctrl_d = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_a = edu_if.rs1_data;
  assign alu_b = alu_src_d ? edu_if.imm : edu_if.rs2_data;

  // 32-bit ALU; shifts use the low five bits of B, arithmetic wraps
  always_comb begin
    alu_result_d = 32'h0;
    case (alu_ctrl_d)
      ALU_AND:  alu_result_d = alu_a & alu_b;
      ALU_OR:   alu_result_d = alu_a | alu_b;
      ALU_ADD:  alu_result_d = alu_a + alu_b;
      ALU_XOR:  alu_result_d = alu_a ^ alu_b;
      ALU_SLL:  alu_result_d = alu_a << alu_b[4:0];
      ALU_SRL:  alu_result_d = alu_a >> alu_b[4:0];
      ALU_SUB:  alu_result_d = alu_a - alu_b;
      ALU_SLT:  alu_result_d = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result_d = {31'h0, alu_a < alu_b};
      ALU_SRA:  alu_result_d = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default:  alu_result_d = 32'h0;
    endcase
    zero_d = (alu_result_d == 32'h0);
  end

  // Branch condition on the register operands, independent of the ALU B mux
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (edu_if.rs1_data == edu_if.rs2_data);
      3'b001:  br_cond = (edu_if.rs1_data != edu_if.rs2_data);
      3'b100:  br_cond = ($signed(edu_if.rs1_data) <  $signed(edu_if.rs2_data));
      3'b101:  br_cond = ($signed(edu_if.rs1_data) >= $signed(edu_if.rs2_data));
      3'b110:  br_cond = (edu_if.rs1_data <  edu_if.rs2_data);
      3'b111:  br_cond = (edu_if.rs1_data >= edu_if.rs2_data);
      default: br_cond = 1'b0;
    endcase
    branch_taken_d = branch_d & br_cond;
  end

  assign jalr_sum = edu_if.rs1_data + edu_if.imm;

  // Destination and return address; jalr clears bit 0 of its register-relative target
  always_comb begin
    target_d = edu_if.pc + edu_if.imm;
    if (opcode == OP_JALR) begin
      target_d = {jalr_sum[31:1], 1'b0};
    end
    link_d = edu_if.pc + 32'd4;
  end

  // Output register: capture on in_valid, otherwise drop the strobes and hold the data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      alu_src_q      <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      alu_op_q       <= 2'b00;
      alu_ctrl_q     <= 4'b0000;
      alu_result_q   <= 32'h0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      target_q       <= 32'h0;
      link_q         <= 32'h0;
    end else if (edu_if.in_valid) begin
      out_valid_q    <= 1'b1;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      alu_src_q      <= alu_src_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
      alu_op_q       <= alu_op_d;
      alu_ctrl_q     <= alu_ctrl_d;
      alu_result_q   <= alu_result_d;
      zero_q         <= zero_d;
      branch_taken_q <= branch_taken_d;
      target_q       <= target_d;
      link_q         <= link_d;
    end else begin
      out_valid_q    <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      branch_taken_q <= 1'b0;
    end
  end

  assign edu_if.out_valid    = out_valid_q;
  assign edu_if.reg_write    = reg_write_q;
  assign edu_if.mem_read     = mem_read_q;
  assign edu_if.mem_write    = mem_write_q;
  assign edu_if.mem_to_reg   = mem_to_reg_q;
  assign edu_if.alu_src      = alu_src_q;
  assign edu_if.branch       = branch_q;
  assign edu_if.jump         = jump_q;
  assign edu_if.alu_op       = alu_op_q;
  assign edu_if.alu_ctrl     = alu_ctrl_q;
  assign edu_if.alu_result   = alu_result_q;
  assign edu_if.zero         = zero_q;
  assign edu_if.branch_taken = branch_taken_q;
  assign edu_if.target       = target_q;
  assign edu_if.link         = link_q;

endmodule

// File: tb/tb_exec_decode_unit.sv
// tb/tb_exec_decode_unit.sv - directed vector bench for exec_decode_unit
module tb_exec_decode_unit;

  logic clk;
  logic rst_n;

  exec_decode_unit_if edu_if ();

  exec_decode_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .edu_if (edu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] e_res;
    logic [3:0]  e_ctrl;
    logic [1:0]  e_op;
    logic        e_zero;
    logic [6:0]  e_strb;  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
    logic        e_bt;
    logic [31:0] e_tgt;
    logic [31:0] e_link;
  } vec_t;

  vec_t vecs [$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
    input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] e_res,
    input logic [3:0] e_ctrl, input logic [1:0] e_op, input logic e_zero,
    input logic [6:0] e_strb, input logic e_bt, input logic [31:0] e_tgt,
    input logic [31:0] e_link);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.e_res = e_res; v.e_ctrl = e_ctrl; v.e_op = e_op; v.e_zero = e_zero;
    v.e_strb = e_strb; v.e_bt = e_bt; v.e_tgt = e_tgt; v.e_link = e_link;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=0x%08h exp=0x%08h", name, idx, act, exp);
    end
  endtask

  function automatic logic [111:0] all_outputs();
    return {edu_if.out_valid, edu_if.reg_write, edu_if.mem_read, edu_if.mem_write,
            edu_if.mem_to_reg, edu_if.alu_src, edu_if.branch, edu_if.jump,
            edu_if.alu_op, edu_if.alu_ctrl, edu_if.alu_result, edu_if.zero,
            edu_if.branch_taken, edu_if.target, edu_if.link};
  endfunction

  task automatic chk_all_zero(input string name);
    logic [111:0] a;
    a = all_outputs();
    checks++;
    if (a !== 112'h0) begin
      failures++;
      $display("FAIL %s got=0x%028h exp=0", name, a);
    end
  endtask

  task automatic drive(input logic valid, input vec_t v);
    edu_if.in_valid = valid;
    edu_if.instr    = v.instr;
    edu_if.pc       = v.pc;
    edu_if.rs1_data = v.rs1;
    edu_if.rs2_data = v.rs2;
    edu_if.imm      = v.imm;
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    logic [6:0] strb;
    strb = {edu_if.reg_write, edu_if.mem_read, edu_if.mem_write, edu_if.mem_to_reg,
            edu_if.alu_src, edu_if.branch, edu_if.jump};
    chk("out_valid",    i, {31'h0, edu_if.out_valid},    32'h1);
    chk("alu_result",   i, edu_if.alu_result,            v.e_res);
    chk("alu_ctrl",     i, {28'h0, edu_if.alu_ctrl},     {28'h0, v.e_ctrl});
    chk("alu_op",       i, {30'h0, edu_if.alu_op},       {30'h0, v.e_op});
    chk("zero",         i, {31'h0, edu_if.zero},         {31'h0, v.e_zero});
    chk("strobes",      i, {25'h0, strb},                {25'h0, v.e_strb});
    chk("branch_taken", i, {31'h0, edu_if.branch_taken}, {31'h0, v.e_bt});
    chk("target",       i, edu_if.target,                v.e_tgt);
    chk("link",         i, edu_if.link,                  v.e_link);
  endtask

  initial begin
    vec_t idle;
    //               instr         pc            rs1           rs2           imm           result        ctrl     op     z     strobes     bt    target        link
    vecs.push_back(mk(32'h002081B3, 32'h00001000, 32'h00000005, 32'h00000007, 32'h00000000, 32'h0000000C, 4'b0010, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00001000, 32'h00001004)); // add
    vecs.push_back(mk(32'h402081B3, 32'h00001004, 32'h00000005, 32'h00000007, 32'h00000000, 32'hFFFFFFFE, 4'b0110, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00001004, 32'h00001008)); // sub
    vecs.push_back(mk(32'hFFF08093, 32'h00002000, 32'h00000001, 32'h00000055, 32'hFFFFFFFF, 32'h00000000, 4'b0010, 2'b11, 1'b1, 7'b1000100, 1'b0, 32'h00001FFF, 32'h00002004)); // addi -1
    vecs.push_back(mk(32'h4040D113, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000404, 32'hF8000000, 4'b1001, 2'b11, 1'b0, 7'b1000100, 1'b0, 32'h00000404, 32'h00000004)); // srai 4
    vecs.push_back(mk(32'h0020A1B3, 32'h00000010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0111, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000010, 32'h00000014)); // slt
    vecs.push_back(mk(32'h0020B1B3, 32'h00000014, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 4'b1000, 2'b10, 1'b1, 7'b1000000, 1'b0, 32'h00000014, 32'h00000018)); // sltu
    vecs.push_back(mk(32'h00208863, 32'h00000100, 32'h00000009, 32'h00000009, 32'h00000010, 32'h00000000, 4'b0110, 2'b01, 1'b1, 7'b0000010, 1'b1, 32'h00000110, 32'h00000104)); // beq
    vecs.push_back(mk(32'h00209863, 32'h00000100, 32'h00000009, 32'h00000009, 32'h00000010, 32'h00000000, 4'b0110, 2'b01, 1'b1, 7'b0000010, 1'b0, 32'h00000110, 32'h00000104)); // bne
    vecs.push_back(mk(32'h004280E7, 32'h00000040, 32'h00000203, 32'h00000000, 32'h00000004, 32'h00000207, 4'b0010, 2'b00, 1'b0, 7'b1000101, 1'b0, 32'h00000206, 32'h00000044)); // jalr
    vecs.push_back(mk(32'h0000007F, 32'h00000050, 32'h00000003, 32'h00000004, 32'h00000008, 32'h00000007, 4'b0010, 2'b00, 1'b0, 7'b0000000, 1'b0, 32'h00000058, 32'h00000054)); // unknown
    vecs.push_back(mk(32'h0080A283, 32'h00000060, 32'h00001000, 32'h0000DEAD, 32'h00000008, 32'h00001008, 4'b0010, 2'b00, 1'b0, 7'b1101100, 1'b0, 32'h00000068, 32'h00000064)); // lw
    vecs.push_back(mk(32'h0020A623, 32'h00000070, 32'h00002000, 32'h12345678, 32'h0000000C, 32'h0000200C, 4'b0010, 2'b00, 1'b0, 7'b0010100, 1'b0, 32'h0000007C, 32'h00000074)); // sw
    vecs.push_back(mk(32'h020000EF, 32'h00000080, 32'h00000000, 32'h00000000, 32'h00000020, 32'h00000000, 4'b0010, 2'b00, 1'b1, 7'b1000001, 1'b0, 32'h000000A0, 32'h00000084)); // jal
    vecs.push_back(mk(32'h0020C1B3, 32'h00000090, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'h0FF00FF0, 4'b0011, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000090, 32'h00000094)); // xor
    vecs.push_back(mk(32'h0020E1B3, 32'h00000090, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000000, 32'hFFFFF0F0, 4'b0001, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000090, 32'h00000094)); // or
    vecs.push_back(mk(32'h0020F1B3, 32'h00000090, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hF000F000, 4'b0000, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000090, 32'h00000094)); // and
    vecs.push_back(mk(32'h002091B3, 32'h00000090, 32'h00000001, 32'h00000021, 32'h00000000, 32'h00000002, 4'b0100, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000090, 32'h00000094)); // sll, B[4:0] only
    vecs.push_back(mk(32'h0020D1B3, 32'h00000090, 32'h80000000, 32'h0000001F, 32'h00000000, 32'h00000001, 4'b0101, 2'b10, 1'b0, 7'b1000000, 1'b0, 32'h00000090, 32'h00000094)); // srl 31
    vecs.push_back(mk(32'h0020C863, 32'h00000200, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFF0, 32'hFFFFFFFE, 4'b0110, 2'b01, 1'b0, 7'b0000010, 1'b1, 32'h000001F0, 32'h00000204)); // blt signed
    vecs.push_back(mk(32'h0020F863, 32'h00000300, 32'hFFFFFFFF, 32'h00000001, 32'h00000008, 32'hFFFFFFFE, 4'b0110, 2'b01, 1'b0, 7'b0000010, 1'b1, 32'h00000308, 32'h00000304)); // bgeu
    vecs.push_back(mk(32'h0020A863, 32'h00000000, 32'h00000005, 32'h00000005, 32'h00000004, 32'h00000000, 4'b0110, 2'b01, 1'b1, 7'b0000010, 1'b0, 32'h00000004, 32'h00000004)); // funct3 010 branch
    vecs.push_back(mk(32'h00000013, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0010, 2'b11, 1'b1, 7'b1000100, 1'b0, 32'hFFFFFFFC, 32'h00000000)); // link wraps

    idle = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 2'h0, 1'b0, 7'h0, 1'b0, 32'h0, 32'h0);

    // reset asserted from time zero, before any clock edge
    rst_n = 1'b0;
    drive(1'b1, vecs[0]);
    #2;
    chk_all_zero("reset_initial");
    @(posedge clk); #1;
    chk_all_zero("reset_held_edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, idle);

    // back-to-back table, one instruction per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i]);
      @(posedge clk); #1;
      chk_vec(i, vecs[i]);
    end

    // in_valid low: strobes clear, data holds from the store
    @(negedge clk);
    drive(1'b1, vecs[11]);
    @(posedge clk); #1;
    chk("hold_pre_mem_write", 11, {31'h0, edu_if.mem_write}, 32'h1);
    @(negedge clk);
    drive(1'b0, vecs[0]);
    @(posedge clk); #1;
    chk("idle_out_valid",  -1, {31'h0, edu_if.out_valid}, 32'h0);
    chk("idle_mem_write",  -1, {31'h0, edu_if.mem_write}, 32'h0);
    chk("idle_hold_res",   -1, edu_if.alu_result,         32'h0000200C);
    chk("idle_hold_src",   -1, {31'h0, edu_if.alu_src},   32'h1);
    chk("idle_hold_tgt",   -1, edu_if.target,             32'h0000007C);
    chk("idle_hold_link",  -1, edu_if.link,               32'h00000074);

    // in_valid low after a taken branch clears branch and branch_taken
    @(negedge clk);
    drive(1'b1, vecs[6]);
    @(posedge clk); #1;
    chk("pre_bt", 6, {31'h0, edu_if.branch_taken}, 32'h1);
    @(negedge clk);
    drive(1'b0, vecs[6]);
    @(posedge clk); #1;
    chk("idle_bt",     -1, {31'h0, edu_if.branch_taken}, 32'h0);
    chk("idle_branch", -1, {31'h0, edu_if.branch},       32'h0);
    chk("idle_zero",   -1, {31'h0, edu_if.zero},         32'h1);

    // asynchronous reset mid-stream, then first capture after release
    @(negedge clk);
    drive(1'b1, vecs[8]);
    @(posedge clk); #1;
    chk("pre_reset_jump", 8, {31'h0, edu_if.jump}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    @(posedge clk); #1;
    chk_all_zero("reset_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("reset_released");
    @(posedge clk); #1;
    chk_vec(8, vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
